// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width helpers shared by the async FIFO write and read controllers
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend narrower pointers.
    localparam int PTR_MAX_W = 32;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down; zero-extended upper bits leave the result unchanged.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: producer/synchroniser/memory-facing signals of the FIFO write controller
interface fifo_wr_ctrl_if #(parameter int ADDR_W = 3);
    localparam int PW = ADDR_W + 1;
    logic              w_inc;
    logic [PW-1:0]     sync_rd_gray;
    logic [PW-1:0]     afull_thresh;
    logic              clr_ovf;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [PW-1:0]     gray_w_ptr;
    logic              full;
    logic              almost_full;
    logic [PW-1:0]     w_level;
    logic              overflow;

    modport master (
        output w_inc, sync_rd_gray, afull_thresh, clr_ovf,
        input  w_en, w_addr, gray_w_ptr, full, almost_full, w_level, overflow
    );

    modport slave (
        input  w_inc, sync_rd_gray, afull_thresh, clr_ovf,
        output w_en, w_addr, gray_w_ptr, full, almost_full, w_level, overflow
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational gray-to-binary pointer conversion
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int PW = 4
) (
    input  logic [PW-1:0] gray_i,
    output logic [PW-1:0] bin_o
);
    assign bin_o = PW'(gray2bin(PTR_MAX_W'(gray_i)));
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side pointer, gray pointer, full/almost-full, level and overflow
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic          w_clk,
    input  logic          w_rstn,
    fifo_wr_ctrl_if.slave wif
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = depth_of(ADDR_W);

    if (DEPTH < 4) begin : g_addr_w_check
        $error("fifo_wr_ctrl: ADDR_W must be >= 2");
    end

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rd_bin;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;

    fifo_gray2bin #(.PW(PW)) u_rd_g2b (
        .gray_i (wif.sync_rd_gray),
        .bin_o  (rd_bin)
    );

    // Full compares against the read pointer one lap behind: top two gray bits inverted.
    always_comb begin
        wif.w_en = wif.w_inc & ~full_q;
        w_ptr_d  = w_ptr_q + PW'(wif.w_en);
        gray_d   = PW'(bin2gray(PTR_MAX_W'(w_ptr_d)));
        level_d  = w_ptr_d - rd_bin;
        full_d   = gray_d == {~wif.sync_rd_gray[PW-1:PW-2], wif.sync_rd_gray[PW-3:0]};
        afull_d  = level_d >= wif.afull_thresh;
        ovf_d    = (wif.w_inc & full_q) | (ovf_q & ~wif.clr_ovf);
    end

    // Pointer, gray pointer and status flags all update on the same edge.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            w_ptr_q <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wif.w_addr      = w_ptr_q[ADDR_W-1:0];
    assign wif.gray_w_ptr  = gray_q;
    assign wif.w_level     = level_q;
    assign wif.full        = full_q;
    assign wif.almost_full = afull_q;
    assign wif.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed checks of the FIFO write controller with ADDR_W=3
module tb_fifo_wr_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   passed = 0;
    int   total = 0;

    fifo_wr_ctrl_if #(.ADDR_W(3)) wif ();

    fifo_wr_ctrl #(.ADDR_W(3)) dut (
        .w_clk  (clk),
        .w_rstn (rstn),
        .wif    (wif)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        wif.w_inc = 1'b0;
        wif.clr_ovf = 1'b0;
        wif.sync_rd_gray = 4'd0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        wif.w_inc = 1'b1;
        #1;
        total++; if (wif.gray_w_ptr !== 4'd0 || wif.w_level !== 4'd0) $display("FAIL reset_initial gray=%b level=%0d required 0/0", wif.gray_w_ptr, wif.w_level); else passed++;
        @(negedge clk);
        rstn = 1'b1;
        step();
        step();
        total++; if (wif.w_addr !== 3'd2 || wif.w_level !== 4'd2) $display("FAIL reset_prewrites addr=%0d level=%0d required 2/2", wif.w_addr, wif.w_level); else passed++;
        #2;
        rstn = 1'b0;
        #1;
        total++; if ({wif.gray_w_ptr, wif.w_level, wif.full, wif.almost_full, wif.overflow, wif.w_addr} !== 14'd0)
            $display("FAIL reset_async gray=%b level=%0d full=%b af=%b ovf=%b addr=%0d required all 0", wif.gray_w_ptr, wif.w_level, wif.full, wif.almost_full, wif.overflow, wif.w_addr);
        else passed++;
        @(negedge clk);
        wif.w_inc = 1'b0;
        rstn = 1'b1;
        step();
        total++; if (wif.w_addr !== 3'd0 || wif.gray_w_ptr !== 4'd0) $display("FAIL reset_release addr=%0d gray=%b required 0/0000", wif.w_addr, wif.gray_w_ptr); else passed++;
    endtask

    task automatic test_gray_sequence();
        do_reset();
        wif.w_inc = 1'b1;
        repeat (3) step();
        wif.w_inc = 1'b0;
        total++; if (wif.w_addr !== 3'd3) $display("FAIL gray_addr got %0d required 3", wif.w_addr); else passed++;
        total++; if (wif.gray_w_ptr !== 4'b0010) $display("FAIL gray_ptr got %b required 0010", wif.gray_w_ptr); else passed++;
        total++; if (wif.w_level !== 4'd3 || wif.almost_full !== 1'b0) $display("FAIL gray_level level=%0d af=%b required 3/0", wif.w_level, wif.almost_full); else passed++;
    endtask

    task automatic test_fill();
        do_reset();
        wif.w_inc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++; if (wif.almost_full !== (k >= 6)) $display("FAIL fill_af write=%0d got %b required %b", k, wif.almost_full, k >= 6); else passed++;
        end
        total++; if (wif.full !== 1'b1 || wif.w_level !== 4'd8) $display("FAIL fill_full full=%b level=%0d required 1/8", wif.full, wif.w_level); else passed++;
        total++; if (wif.gray_w_ptr !== 4'b1100) $display("FAIL fill_gray got %b required 1100", wif.gray_w_ptr); else passed++;
        #1;
        total++; if (wif.w_en !== 1'b0) $display("FAIL fill_wen_blocked got %b required 0", wif.w_en); else passed++;
        step();
        total++; if (wif.w_addr !== 3'd0 || wif.gray_w_ptr !== 4'b1100) $display("FAIL fill_ptr_hold addr=%0d gray=%b required 0/1100", wif.w_addr, wif.gray_w_ptr); else passed++;
        total++; if (wif.overflow !== 1'b1) $display("FAIL fill_overflow got %b required 1", wif.overflow); else passed++;
    endtask

    task automatic test_drain();
        wif.w_inc = 1'b0;
        wif.sync_rd_gray = 4'b0011;
        step();
        total++; if (wif.full !== 1'b0 || wif.w_level !== 4'd6 || wif.almost_full !== 1'b1)
            $display("FAIL drain_status full=%b level=%0d af=%b required 0/6/1", wif.full, wif.w_level, wif.almost_full);
        else passed++;
        total++; if (wif.overflow !== 1'b1) $display("FAIL drain_ovf_sticky got %b required 1", wif.overflow); else passed++;
        wif.clr_ovf = 1'b1;
        step();
        wif.clr_ovf = 1'b0;
        total++; if (wif.overflow !== 1'b0) $display("FAIL drain_clr got %b required 0", wif.overflow); else passed++;
        wif.w_inc = 1'b1;
        repeat (2) step();
        total++; if (wif.full !== 1'b1 || wif.w_level !== 4'd8 || wif.gray_w_ptr !== 4'b1111)
            $display("FAIL drain_refill full=%b level=%0d gray=%b required 1/8/1111", wif.full, wif.w_level, wif.gray_w_ptr);
        else passed++;
        wif.clr_ovf = 1'b1;
        step();
        wif.clr_ovf = 1'b0;
        total++; if (wif.overflow !== 1'b1) $display("FAIL drain_set_wins got %b required 1", wif.overflow); else passed++;
        wif.sync_rd_gray = gray4(4'd3);
        #1;
        total++; if (wif.w_en !== 1'b0) $display("FAIL drain_wr_while_full wen=%b required 0", wif.w_en); else passed++;
        step();
        wif.w_inc = 1'b0;
        total++; if (wif.w_addr !== 3'd2 || wif.full !== 1'b0 || wif.w_level !== 4'd7)
            $display("FAIL drain_simul addr=%0d full=%b level=%0d required 2/0/7", wif.w_addr, wif.full, wif.w_level);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] p;
        do_reset();
        p = 4'd0;
        wif.w_inc = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wif.sync_rd_gray = gray4(p);
            step();
            p = p + 4'd1;
            total++; if (wif.w_level !== 4'd1 || wif.full !== 1'b0) $display("FAIL wrap_level write=%0d level=%0d full=%b required 1/0", k, wif.w_level, wif.full); else passed++;
        end
        wif.w_inc = 1'b0;
        total++; if (wif.gray_w_ptr !== 4'b0000 || wif.w_addr !== 3'd0) $display("FAIL wrap_ptr gray=%b addr=%0d required 0000/0", wif.gray_w_ptr, wif.w_addr); else passed++;
    endtask

    task automatic test_thresh_edges();
        wif.afull_thresh = 4'd0;
        do_reset();
        step();
        total++; if (wif.almost_full !== 1'b1 || wif.w_level !== 4'd0) $display("FAIL thresh0 af=%b level=%0d required 1/0", wif.almost_full, wif.w_level); else passed++;
        wif.afull_thresh = 4'd9;
        do_reset();
        wif.w_inc = 1'b1;
        repeat (8) step();
        wif.w_inc = 1'b0;
        total++; if (wif.full !== 1'b1 || wif.almost_full !== 1'b0) $display("FAIL thresh9 full=%b af=%b required 1/0", wif.full, wif.almost_full); else passed++;
        wif.afull_thresh = 4'd6;
    endtask

    initial begin
        wif.w_inc = 1'b0;
        wif.clr_ovf = 1'b0;
        wif.sync_rd_gray = 4'd0;
        wif.afull_thresh = 4'd6;
        @(negedge clk);
        test_reset();
        test_gray_sequence();
        test_fill();
        test_drain();
        test_wrap();
        test_thresh_edges();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
